// File: rtl/lfsr_gen.sv
// lfsr_gen -- Fibonacci-style XNOR LFSR with a programmable tick divider.
//
// Ports:
//   clk         : single clock, all state on the rising edge
//   rst_n       : asynchronous active-low reset
//   enable      : global run enable (load still acts when low)
//   mode        : 0 = free-run on divider tick, 1 = manual step only
//   div_max     : divider terminal count (tick period is div_max+1 cycles)
//   step        : single-cycle manual shift request (mode 1 only)
//   load        : synchronous state load strobe, overrides any shift
//   load_value  : value loaded on load
//   out         : current LFSR state
//   shift_pulse : one-cycle pulse following each shift
//   wrap        : one-cycle pulse when a normal shift returns the state to SEED
//   lockup      : one-cycle pulse when the all-ones lock state is recovered
module lfsr_gen #(
  parameter int unsigned         WIDTH     = 4,
  parameter logic [WIDTH-1:0]    TAPS      = 4'b1100,
  parameter logic [WIDTH-1:0]    SEED      = '0,
  parameter int unsigned         DIV_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 mode,
  input  logic [DIV_WIDTH-1:0] div_max,
  input  logic                 step,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_value,
  output logic [WIDTH-1:0]     out,
  output logic                 shift_pulse,
  output logic                 wrap,
  output logic                 lockup
);

  logic [WIDTH-1:0]     state_q;
  logic [WIDTH-1:0]     shifted;
  logic [WIDTH-1:0]     next_state;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;
  logic                 feedback;
  logic                 locked;
  logic                 tick;
  logic                 step_ok;
  logic                 do_shift;

  always_comb begin
    feedback   = ~^(state_q & TAPS);
    shifted    = {state_q[WIDTH-2:0], feedback};
    // All-ones is the XNOR lock state: shifting it would reproduce itself.
    locked     = &state_q;
    next_state = locked ? SEED : shifted;

    // ">=" so a counter stranded above a newly lowered div_max ticks at once.
    tick     = enable && !mode && (cnt_q >= div_max);
    step_ok  = enable && mode && step;
    do_shift = tick || step_ok;

    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (enable) begin
      if (mode || tick) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEED;
      cnt_q       <= '0;
      shift_pulse <= 1'b0;
      wrap        <= 1'b0;
      lockup      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      shift_pulse <= 1'b0;
      wrap        <= 1'b0;
      lockup      <= 1'b0;
      if (load) begin
        state_q <= load_value;
      end else if (do_shift) begin
        state_q     <= next_state;
        shift_pulse <= 1'b1;
        lockup      <= locked;
        wrap        <= !locked && (shifted == SEED);
      end
    end
  end

  assign out = state_q;

endmodule
